// File: rtl/mult_pkg.sv
// Shared types and default sizing for the shift-add multiplier and its writeback port mapping.
// No logic; no latency; no backpressure.
package mult_pkg;

  localparam int MULT_WIDTH      = 32;
  localparam int MULT_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_port_map.sv
// Steers the product halves onto the two register-file write ports so that register 0 never takes data.
// Combinational; no backpressure (result is registered by the parent in its WRITE cycle).
module mult_port_map
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter int REG_ADDR_W = MULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] dest_hi,
  input  logic [REG_ADDR_W-1:0] dest_lo,
  input  logic [WIDTH-1:0]      prod_hi,
  input  logic [WIDTH-1:0]      prod_lo,
  output logic [REG_ADDR_W-1:0] addr1,
  output logic [WIDTH-1:0]      data1,
  output logic [REG_ADDR_W-1:0] addr2,
  output logic [WIDTH-1:0]      data2,
  output logic                  wr_en
);

  always_comb begin
    addr1 = dest_hi;
    data1 = prod_hi;
    addr2 = dest_lo;
    data2 = prod_lo;
    wr_en = 1'b1;
    // A port that would hit r0 duplicates the surviving write; equal
    // destinations collapse onto the low half so the outcome is fixed.
    if (dest_hi == '0 && dest_lo == '0) begin
      wr_en = 1'b0;
    end else if (dest_hi == '0 || dest_hi == dest_lo) begin
      addr1 = dest_lo;
      data1 = prod_lo;
    end else if (dest_lo == '0) begin
      addr2 = dest_hi;
      data2 = prod_hi;
    end
  end

endmodule

// File: rtl/mult_writeback.sv
// Sequential shift-add MULT/MULTU writing hi/lo halves to both register-file ports in one cycle.
// Latency WIDTH+1 cycles start->done (MULT_EARLY_TERM_EN: stops once multiplier is exhausted, min 2).
// No queueing: start is ignored while busy.
module mult_writeback
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter int REG_ADDR_W = MULT_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest_hi,
  input  logic [REG_ADDR_W-1:0] dest_lo,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] write_register1,
  output logic [REG_ADDR_W-1:0] write_register2,
  output logic [WIDTH-1:0]      write_data1,
  output logic [WIDTH-1:0]      write_data2,
  output logic                  signal_reg_write
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                 state, state_next;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]       mplier;
  logic [CNT_W-1:0]       count;
  logic                   neg_result;
  logic [REG_ADDR_W-1:0]  dest_hi_q, dest_lo_q;

  logic [WIDTH-1:0]       mag_a, mag_b;
  logic                   finish;
  logic [2*WIDTH-1:0]     product;
  logic [REG_ADDR_W-1:0]  map_addr1, map_addr2;
  logic [WIDTH-1:0]       map_data1, map_data2;
  logic                   map_wr_en;

  // Most-negative operand negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a   = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b   = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    product = neg_result ? -acc : acc;
  end

  always_comb begin
    finish = (count == '0);
`ifdef MULT_EARLY_TERM_EN
    // At least one step must have run so the accumulator reflects the operands.
    if (mplier == '0 && count != CNT_W'(WIDTH)) begin
      finish = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (finish) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mult_port_map #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_port_map (
    .dest_hi (dest_hi_q),
    .dest_lo (dest_lo_q),
    .prod_hi (product[2*WIDTH-1:WIDTH]),
    .prod_lo (product[WIDTH-1:0]),
    .addr1   (map_addr1),
    .data1   (map_data1),
    .addr2   (map_addr2),
    .data2   (map_data2),
    .wr_en   (map_wr_en)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      count            <= '0;
      neg_result       <= 1'b0;
      dest_hi_q        <= '0;
      dest_lo_q        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      signal_reg_write <= 1'b0;
      write_register1  <= '0;
      write_register2  <= '0;
      write_data1      <= '0;
      write_data2      <= '0;
    end else begin
      busy <= (state_next != IDLE);
      unique case (state)
        IDLE: begin
          done             <= 1'b0;
          signal_reg_write <= 1'b0;
          if (start) begin
            acc        <= '0;
            mcand      <= {{WIDTH{1'b0}}, mag_a};
            mplier     <= mag_b;
            count      <= CNT_W'(WIDTH);
            neg_result <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            dest_hi_q  <= dest_hi;
            dest_lo_q  <= dest_lo;
          end
        end
        RUN: begin
          if (finish) begin
            // Outputs load on entry so WRITE presents them straight from flops.
            write_register1  <= map_addr1;
            write_data1      <= map_data1;
            write_register2  <= map_addr2;
            write_data2      <= map_data2;
            signal_reg_write <= map_wr_en;
            done             <= 1'b1;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
          end
        end
        WRITE: begin
          done             <= 1'b0;
          signal_reg_write <= 1'b0;
        end
        default: begin
          done             <= 1'b0;
          signal_reg_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_writeback.sv
// Randomised and directed bench for mult_writeback against a 64-bit arithmetic reference model.
module tb_mult_writeback;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  dest_hi = '0;
  logic [4:0]  dest_lo = '0;
  logic        busy, done, signal_reg_write;
  logic [4:0]  write_register1, write_register2;
  logic [31:0] write_data1, write_data2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [4:0]  dh, dl;
    logic [31:0] hi, lo;
  } vec_t;

  mult_writeback dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .signed_op        (signed_op),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .dest_hi          (dest_hi),
    .dest_lo          (dest_lo),
    .busy             (busy),
    .done             (done),
    .write_register1  (write_register1),
    .write_register2  (write_register2),
    .write_data1      (write_data1),
    .write_data2      (write_data2),
    .signal_reg_write (signal_reg_write)
  );

  always #5 clock = ~clock;

  // Reference: exact product via 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, b, input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  // Reference: start->done cycles; early termination stops after the top set bit of |b|.
  function automatic int exp_lat(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int steps;
    mag = (s && b[31]) ? (32'h0 - b) : b;
    steps = 32;
`ifdef MULT_EARLY_TERM_EN
    steps = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) steps = i + 1;
`endif
    return steps + 1;
  endfunction

  // Reference: list the writes that are allowed to happen, then lay them onto the two ports.
  function automatic void ref_ports(input logic [4:0] dh, dl, input logic [63:0] p,
                                    output logic en, output logic [4:0] r1, r2,
                                    output logic [31:0] d1, d2);
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    if (dh != 0 && dh != dl) begin wa.push_back(dh); wd.push_back(p[63:32]); end
    if (dl != 0)             begin wa.push_back(dl); wd.push_back(p[31:0]);  end
    en = (wa.size() > 0);
    r1 = '0; r2 = '0; d1 = '0; d2 = '0;
    if (wa.size() == 1) begin
      r1 = wa[0]; d1 = wd[0]; r2 = wa[0]; d2 = wd[0];
    end else if (wa.size() == 2) begin
      r1 = wa[0]; d1 = wd[0]; r2 = wa[1]; d2 = wd[1];
    end
  endfunction

  // Drive one multiply and record what the DUT does; poke>0 re-asserts start mid-run.
  task automatic mult_op(input logic [31:0] a, b, input logic s, input logic [4:0] dh, dl,
                         input int poke, output int lat, output logic [4:0] r1, r2,
                         output logic [31:0] d1, d2, output int wcnt, dcnt,
                         output logic busy_mid, busy_end, output logic [31:0] d1_end);
    @(negedge clock);
    operand_a = a; operand_b = b; signed_op = s; dest_hi = dh; dest_lo = dl; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    busy_mid = busy;
    lat = 0; wcnt = 0; dcnt = 0; r1 = '0; r2 = '0; d1 = '0; d2 = '0;
    while (lat < 100 && dcnt == 0) begin
      @(posedge clock);
      lat++;
      #1;
      start = 1'b0; operand_a = a; operand_b = b; signed_op = s; dest_hi = dh; dest_lo = dl;
      @(negedge clock);
      wcnt += int'(signal_reg_write);
      if (done) begin
        dcnt = 1;
        r1 = write_register1; d1 = write_data1; r2 = write_register2; d2 = write_data2;
      end else if (lat == poke) begin
        start = 1'b1; operand_a = ~a; operand_b = b ^ 32'h5; signed_op = ~s;
        dest_hi = dh ^ 5'h1; dest_lo = dl ^ 5'h2;
      end
    end
    repeat (3) begin
      @(negedge clock);
      wcnt += int'(signal_reg_write);
      dcnt += int'(done);
    end
    busy_end = busy;
    d1_end = write_data1;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({busy, done, signal_reg_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/wr=%b required 000", {busy, done, signal_reg_write});
    end
    vectors++;
    if ({write_register1, write_register2, write_data1, write_data2} !== '0) begin
      miscompares++;
      $display("FAIL reset_ports: r1=%0d r2=%0d d1=%h d2=%h required all zero",
               write_register1, write_register2, write_data1, write_data2);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if ({busy, done, signal_reg_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy/done/wr=%b required 000", {busy, done, signal_reg_write});
    end
  endtask

  task automatic test_directed;
    vec_t tbl[11];
    int lat, wcnt, dcnt;
    logic [4:0] r1, r2, er1, er2;
    logic [31:0] d1, d2, ed1, ed2, d1e;
    logic bm, be, en;
    tbl[0]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 5'd2,  5'd3,  32'h0000_0000, 32'h0000_000F};
    tbl[1]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 5'd4,  5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[2]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 5'd4,  5'd5,  32'h0000_0002, 32'hFFFF_FFFA};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 5'd6,  5'd8,  32'h4000_0000, 32'h0000_0000};
    tbl[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd10, 5'd11, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[5]  = '{32'h1234_5678, 32'h0000_0010, 1'b0, 5'd0,  5'd7,  32'h0000_0001, 32'h2345_6780};
    tbl[6]  = '{32'h0000_0007, 32'h0000_0009, 1'b0, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_003F};
    tbl[7]  = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 5'd9,  5'd9,  32'h0000_0000, 32'hFFFF_FFFF};
    tbl[8]  = '{32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 5'd3,  5'd0,  32'h0000_0000, 32'hDEAD_BEEF};
    tbl[9]  = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 5'd3,  5'd4,  32'h0000_0000, 32'h0000_0000};
    tbl[10] = '{32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 5'd12, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    foreach (tbl[i]) begin
      mult_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].dh, tbl[i].dl, 0,
              lat, r1, r2, d1, d2, wcnt, dcnt, bm, be, d1e);
      ref_ports(tbl[i].dh, tbl[i].dl, {tbl[i].hi, tbl[i].lo}, en, er1, er2, ed1, ed2);
      vectors++;
      if (lat !== exp_lat(tbl[i].b, tbl[i].s)) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, exp_lat(tbl[i].b, tbl[i].s));
      end
      vectors++;
      if (dcnt !== 1 || wcnt !== int'(en)) begin
        miscompares++;
        $display("FAIL dir%0d_pulses: done=%0d wr=%0d required done=1 wr=%0d", i, dcnt, wcnt, int'(en));
      end
      if (en) begin
        vectors++;
        if ({r1, d1, r2, d2} !== {er1, ed1, er2, ed2}) begin
          miscompares++;
          $display("FAIL dir%0d_ports: (%0d,%h)(%0d,%h) required (%0d,%h)(%0d,%h)",
                   i, r1, d1, r2, d2, er1, ed1, er2, ed2);
        end
      end
      vectors++;
      if (bm !== 1'b1 || be !== 1'b0 || d1e !== d1) begin
        miscompares++;
        $display("FAIL dir%0d_busy_hold: busy_mid=%b busy_end=%b d1_end=%h required 1 0 %h",
                 i, bm, be, d1e, d1);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat, wcnt, dcnt;
    logic [4:0] r1, r2, er1, er2;
    logic [31:0] d1, d2, ed1, ed2, d1e;
    logic bm, be, en;
    logic [31:0] a, b;
    a = 32'h0BAD_F00D;
    b = 32'h9000_0123;
    mult_op(a, b, 1'b0, 5'd14, 5'd15, 10, lat, r1, r2, d1, d2, wcnt, dcnt, bm, be, d1e);
    ref_ports(5'd14, 5'd15, ref_prod(a, b, 1'b0), en, er1, er2, ed1, ed2);
    vectors++;
    if (lat !== exp_lat(b, 1'b0) || dcnt !== 1 || wcnt !== 1) begin
      miscompares++;
      $display("FAIL ignore_start_timing: lat=%0d done=%0d wr=%0d required %0d 1 1",
               lat, dcnt, wcnt, exp_lat(b, 1'b0));
    end
    vectors++;
    if ({r1, d1, r2, d2} !== {er1, ed1, er2, ed2}) begin
      miscompares++;
      $display("FAIL ignore_start_ports: (%0d,%h)(%0d,%h) required (%0d,%h)(%0d,%h)",
               r1, d1, r2, d2, er1, ed1, er2, ed2);
    end
  endtask

  task automatic test_reset_abort;
    int wr_seen, done_seen;
    @(negedge clock);
    operand_a = 32'h7FFF_FFFF; operand_b = 32'h8000_0001; signed_op = 1'b0;
    dest_hi = 5'd20; dest_lo = 5'd21; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, signal_reg_write} !== 3'b000 || write_data1 !== '0 || write_register2 !== '0) begin
      miscompares++;
      $display("FAIL abort_immediate: busy/done/wr=%b d1=%h r2=%0d required 000 0 0",
               {busy, done, signal_reg_write}, write_data1, write_register2);
    end
    wr_seen = 0; done_seen = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      wr_seen += int'(signal_reg_write);
      done_seen += int'(done | busy);
    end
    vectors++;
    if (wr_seen !== 0 || done_seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_write: wr cycles=%0d done/busy cycles=%0d required 0 0", wr_seen, done_seen);
    end
  endtask

  task automatic test_random;
    int lat, wcnt, dcnt;
    logic [4:0] r1, r2, er1, er2, dh, dl;
    logic [31:0] a, b, d1, d2, ed1, ed2, d1e;
    logic bm, be, en, s;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 3));
        1:       b = $urandom >> $urandom_range(0, 31);
        2:       b = 32'h0 - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      dh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dl = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 5) == 0) dl = dh;
      mult_op(a, b, s, dh, dl, 0, lat, r1, r2, d1, d2, wcnt, dcnt, bm, be, d1e);
      ref_ports(dh, dl, ref_prod(a, b, s), en, er1, er2, ed1, ed2);
      vectors++;
      if (lat !== exp_lat(b, s) || dcnt !== 1 || wcnt !== int'(en)) begin
        miscompares++;
        $display("FAIL rnd%0d_timing: lat=%0d done=%0d wr=%0d required %0d 1 %0d",
                 n, lat, dcnt, wcnt, exp_lat(b, s), int'(en));
      end
      if (en) begin
        vectors++;
        if ({r1, d1, r2, d2} !== {er1, ed1, er2, ed2}) begin
          miscompares++;
          $display("FAIL rnd%0d_ports a=%h b=%h s=%b: (%0d,%h)(%0d,%h) required (%0d,%h)(%0d,%h)",
                   n, a, b, s, r1, d1, r2, d2, er1, ed1, er2, ed2);
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
